// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready load, frame-start marker and done pulse.
// Optional even-parity bit after the data bits when PISO_PARITY_EN is defined.
module piso_serializer #(
   parameter int WIDTH      = 4,
   parameter int BIT_CYCLES = 1,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_first,
   output logic             busy,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int FRAME_BITS = WIDTH + 1;
   localparam logic [$clog2(WIDTH+1)-1:0] LAST_DATA = ($clog2(WIDTH+1))'(WIDTH - 1);
`else
   localparam int FRAME_BITS = WIDTH;
`endif
   localparam int BW = $clog2(WIDTH + 1);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
   localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic [CW-1:0]    cyc_cnt;
`ifdef PISO_PARITY_EN
   logic             parity;
`endif

   // Handshake: a word moves on any rising edge where load_valid and load_ready are both 1.
   logic             bit_end;
   logic             frame_end;
   logic             accept;
   logic [WIDTH-1:0] shreg_next;
   logic             first_bit;
   logic             next_bit;

   always_comb begin
      bit_end    = (state == SHIFT) && (cyc_cnt == LAST_CYC);
      frame_end  = bit_end && (bit_cnt == LAST_BIT);
      load_ready = (state == IDLE) || frame_end;
      accept     = load_valid && load_ready;
      busy       = (state != IDLE);
      shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      first_bit  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      next_bit   = MSB_FIRST ? shreg_next[WIDTH-1] : shreg_next[0];
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         cyc_cnt    <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_first <= 1'b0;
         done       <= 1'b0;
`ifdef PISO_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            // Also taken at frame end, which chains frames with no idle gap.
            state      <= SHIFT;
            shreg      <= load_data;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            sout       <= first_bit;
            sout_valid <= 1'b1;
            sout_first <= 1'b1;
            done       <= frame_end;
`ifdef PISO_PARITY_EN
            parity     <= ^load_data;
`endif
         end else if (frame_end) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_first <= 1'b0;
            done       <= 1'b1;
         end else if (bit_end) begin
            cyc_cnt    <= '0;
            bit_cnt    <= bit_cnt + 1'b1;
            shreg      <= shreg_next;
            sout_first <= 1'b0;
`ifdef PISO_PARITY_EN
            sout       <= (bit_cnt == LAST_DATA) ? parity : next_bit;
`else
            sout       <= next_bit;
`endif
         end else if (state == SHIFT) begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/1 cycle, LSB-first/2 cycles) against a queue model.
`timescale 1ns/1ps
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
   localparam int NB = 5;
   localparam logic [15:0] T1_EXP = 16'b10111;
   localparam logic [15:0] T2_EXP = 16'b0011011000;
   localparam logic [15:0] T3_EXP = 16'b1100000011;
   localparam logic [15:0] T4_EXP = 16'b0000011110;
   localparam logic [15:0] T5_EXP = 16'b01100;
   localparam logic [15:0] T6_EXP = 16'b10010;
`else
   localparam int NB = 4;
   localparam logic [15:0] T1_EXP = 16'b1011;
   localparam logic [15:0] T2_EXP = 16'b00111100;
   localparam logic [15:0] T3_EXP = 16'b11000000;
   localparam logic [15:0] T4_EXP = 16'b00001111;
   localparam logic [15:0] T5_EXP = 16'b0110;
   localparam logic [15:0] T6_EXP = 16'b1001;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] load_data [2];
   logic [1:0] load_valid;
   logic [1:0] load_ready, sout, sout_valid, sout_first, busy, done;

   // Model entry per cycle: {sout_valid, sout, sout_first}
   logic [2:0]  exp_q_0[$];
   logic [2:0]  exp_q_1[$];
   logic [1:0]  exp_done;
   logic [1:0]  accepted;
   logic [15:0] cap [2];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4), .BIT_CYCLES(1), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .clr(clr), .load_data(load_data[0]), .load_valid(load_valid[0]),
      .load_ready(load_ready[0]), .sout(sout[0]), .sout_valid(sout_valid[0]),
      .sout_first(sout_first[0]), .busy(busy[0]), .done(done[0]));

   piso_serializer #(.WIDTH(4), .BIT_CYCLES(2), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .clr(clr), .load_data(load_data[1]), .load_valid(load_valid[1]),
      .load_ready(load_ready[1]), .sout(sout[1]), .sout_valid(sout_valid[1]),
      .sout_first(sout_first[1]), .busy(busy[1]), .done(done[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int q_size(input int u);
      return (u == 0) ? exp_q_0.size() : exp_q_1.size();
   endfunction

   function automatic logic [2:0] q_head(input int u);
      if (q_size(u) == 0) return 3'b000;
      return (u == 0) ? exp_q_0[0] : exp_q_1[0];
   endfunction

   task automatic q_push(input int u, input logic [2:0] e);
      if (u == 0) exp_q_0.push_back(e); else exp_q_1.push_back(e);
   endtask

   task automatic q_pop(input int u);
      if (u == 0) void'(exp_q_0.pop_front()); else void'(exp_q_1.pop_front());
   endtask

   task automatic q_clear(input int u);
      if (u == 0) exp_q_0.delete(); else exp_q_1.delete();
   endtask

   // Expand an accepted word into the per-cycle output sequence it must produce.
   task automatic push_frame(input int u, input logic [3:0] d);
      int   bc;
      logic msb;
      logic b;
      bc  = (u == 0) ? 1 : 2;
      msb = (u == 0);
      for (int i = 0; i < NB; i++) begin
         if (i < 4) b = msb ? d[3-i] : d[i];
         else       b = ^d;
         for (int c = 0; c < bc; c++) q_push(u, {1'b1, b, (i == 0)});
      end
   endtask

   // One clock: check both DUTs at the negedge, then advance the model at the posedge.
   task automatic step();
      logic [2:0] h;
      int         sz;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         h = q_head(u);
         check($sformatf("u%0d_sout_valid", u), sout_valid[u], h[2]);
         check($sformatf("u%0d_sout", u), sout[u], h[1]);
         check($sformatf("u%0d_sout_first", u), sout_first[u], h[0]);
         check($sformatf("u%0d_busy", u), busy[u], q_size(u) > 0);
         check($sformatf("u%0d_load_ready", u), load_ready[u], q_size(u) <= 1);
         check($sformatf("u%0d_done", u), done[u], exp_done[u]);
         if (sout_valid[u] === 1'b1) cap[u] = {cap[u][14:0], sout[u]};
      end
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
         sz = q_size(u);
         if (clr) begin
            q_clear(u);
            exp_done[u] = 1'b0;
            accepted[u] = 1'b0;
         end else begin
            exp_done[u] = (sz == 1);
            accepted[u] = load_valid[u] && (sz <= 1);
            if (sz > 0) q_pop(u);
            if (accepted[u]) push_frame(u, load_data[u]);
         end
      end
      #1;
   endtask

   // Hold a word on the load port until the model says it was taken; valid stays high afterwards.
   task automatic send(input int u, input logic [3:0] d);
      load_valid[u] = 1'b1;
      load_data[u]  = d;
      for (int n = 0; n < 40; n++) begin
         step();
         if (accepted[u]) break;
      end
      check($sformatf("u%0d_accept_timeout", u), accepted[u], 1'b1);
   endtask

   task automatic idle(input int n);
      load_valid = 2'b00;
      repeat (n) step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      clr          = 1'b1;
      load_valid   = 2'b00;
      load_data[0] = 4'h0;
      load_data[1] = 4'h0;
      exp_done     = 2'b00;
      accepted     = 2'b00;
      cap[0]       = '0;
      cap[1]       = '0;
      repeat (3) @(posedge clk);
      #1;
      step();
      clr = 1'b0;
      step();

      cap[0] = '0; send(0, 4'b1011); idle(7);
      check("t1_stream", cap[0], T1_EXP);

      cap[0] = '0; send(0, 4'b0011); send(0, 4'b1100); idle(7);
      check("t2_stream", cap[0], T2_EXP);

      cap[1] = '0; send(1, 4'b0001); idle(13);
      check("t3_stream", cap[1], T3_EXP);

      cap[0] = '0; send(0, 4'b0000); send(0, 4'b1111); idle(7);
      check("t4_stream", cap[0], T4_EXP);

      send(0, 4'b1010);
      load_valid = 2'b00;
      step();
      clr = 1'b1; step();
      clr = 1'b0; step();
      cap[0] = '0; send(0, 4'b0110); idle(7);
      check("t5_stream", cap[0], T5_EXP);

      cap[0] = '0; send(0, 4'b1001); idle(7);
      check("t6_stream", cap[0], T6_EXP);

      for (int n = 0; n < 800; n++) begin
         for (int u = 0; u < 2; u++) begin
            load_valid[u] = ($urandom_range(0, 2) != 0);
            load_data[u]  = 4'($urandom_range(0, 15));
         end
         clr = ($urandom_range(0, 49) == 0);
         step();
      end
      clr = 1'b0;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
